// File: rtl/tone_sched_pkg.sv
// Shared types and defaults for the tone scheduler.
package tone_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } tone_state_t;

    localparam int unsigned DIV_W_DEFAULT = 32;

endpackage

// File: rtl/tone_scheduler_rr_arbiter.sv
// Combinational round-robin pick; the search starts one past the previous winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick[cand] = 1'b1;
                pick_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tone_scheduler.sv
// Time-shares one frequency divider between tone requesters: round-robin grant,
// timed play window, then a fixed silent gap before the next grant.
module tone_scheduler
    import tone_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DIV_W      = DIV_W_DEFAULT,
    parameter int unsigned DUR_W      = 32,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DIV_W-1:0] req_divisor,
    input  logic [NUM_REQ*DUR_W-1:0] req_duration,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [DIV_W-1:0]         divisor,
    output logic                     tone_en,
    output logic                     busy
);

    localparam int unsigned       IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [DUR_W-1:0]  GAP_LEN = DUR_W'(GAP_CYCLES);
    localparam logic [DUR_W-1:0]  ONE     = DUR_W'(1);

    tone_state_t          state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [DUR_W-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 any;
    logic [DIV_W-1:0]     sel_div;
    logic [DUR_W-1:0]     sel_dur;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req      (req),
        .last     (last_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    always_comb begin
        sel_div = req_divisor[32'(pick_idx) * DIV_W +: DIV_W];
        sel_dur = req_duration[32'(pick_idx) * DUR_W +: DUR_W];
    end

    // The owner of an active grant is always the last winner, so last_q doubles as owner.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = '0;
        div_d   = div_q;
        dur_d   = dur_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = pick;
                    div_d   = sel_div;
                    dur_d   = (sel_dur == '0) ? ONE : sel_dur;
                    cnt_d   = ONE;
                    last_d  = pick_idx;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (!req[last_q] || cnt_q == dur_q) begin
                    grant_d = '0;
                    cnt_d   = ONE;
                    if (req[last_q]) begin
                        done_d[last_q] = 1'b1;
                    end
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LEN) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            div_q   <= '0;
            dur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            div_q   <= div_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign divisor = div_q;
    assign tone_en = (state_q == PLAY);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: directed scenarios plus randomized
// grant sequences compared against a transaction-level round-robin model.
module tb_tone_scheduler;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int UW  = 32;
    localparam int GAP = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*DW-1:0] req_divisor = '0;
    logic [N*UW-1:0] req_duration = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [DW-1:0]  divisor;
    logic           tone_en;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] div_m [N];
    logic [31:0] dur_m [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tone_scheduler #(
        .NUM_REQ    (N),
        .DIV_W      (DW),
        .DUR_W      (UW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_divisor  (req_divisor),
        .req_duration (req_duration),
        .grant        (grant),
        .done         (done),
        .divisor      (divisor),
        .tone_en      (tone_en),
        .busy         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [31:0] d, input logic [31:0] u);
        req_divisor[i*DW +: DW]  = d;
        req_duration[i*UW +: UW] = u;
        div_m[i] = d;
        dur_m[i] = u;
    endtask

    task automatic do_reset();
        req = '0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Round-robin rule: first requester found scanning last+1, last+2, ... modulo N.
    function automatic int rr_pick(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // Follows one grant from its first cycle through the gap back to idle.
    task automatic observe(output logic [N-1:0] g0, output logic [31:0] d0, output int start,
                           output int play_len, output logic [N-1:0] done_end,
                           output logic [N-1:0] grant_end, output int pulses,
                           output int gap_len, output bit timeout);
        int budget;
        g0 = '0; d0 = '0; start = 0; play_len = 0; done_end = '0; grant_end = '0;
        pulses = 0; gap_len = 0; timeout = 1'b0; budget = 0;
        do begin
            step();
            budget++;
        end while (grant === '0 && budget < 100);
        if (grant === '0) begin
            timeout = 1'b1;
            return;
        end
        g0 = grant;
        d0 = divisor;
        start = cyc;
        budget = 0;
        while (tone_en === 1'b1 && budget < 200) begin
            if (done !== '0) pulses++;
            play_len++;
            step();
            budget++;
        end
        done_end = done;
        grant_end = grant;
        budget = 0;
        while (busy === 1'b1 && budget < 200) begin
            if (done !== '0) pulses++;
            gap_len++;
            step();
            budget++;
        end
        if (busy !== 1'b0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req = '0;
        step();
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (divisor !== '0) begin errors++; $display("FAIL reset_divisor: got %0d expected 0", divisor); end
        checks++; if (tone_en !== 1'b0) begin errors++; $display("FAIL reset_tone_en: got %b expected 0", tone_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [N-1:0] g0, de, ge;
        logic [31:0] d0;
        int st, pl, pu, gl, req_cyc;
        bit to;
        set_slot(0, 32'd1000, 32'd5);
        req = 4'b0001;
        req_cyc = cyc;
        observe(g0, d0, st, pl, de, ge, pu, gl, to);
        req = '0;
        checks++; if (to) begin errors++; $display("FAIL single_timeout: no completed grant"); end
        checks++; if (st !== req_cyc + 1) begin errors++; $display("FAIL single_latency: got %0d cycles expected 1", st - req_cyc); end
        checks++; if (g0 !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", g0); end
        checks++; if (d0 !== 32'd1000) begin errors++; $display("FAIL single_divisor: got %0d expected 1000", d0); end
        checks++; if (pl !== 5) begin errors++; $display("FAIL single_play_len: got %0d expected 5", pl); end
        checks++; if (de !== 4'b0001) begin errors++; $display("FAIL single_done: got %b expected 0001", de); end
        checks++; if (ge !== 4'b0000) begin errors++; $display("FAIL single_grant_clear: got %b expected 0000", ge); end
        checks++; if (pu !== 1) begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", pu); end
        checks++; if (gl !== GAP) begin errors++; $display("FAIL single_gap_len: got %0d expected %0d", gl, GAP); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] g0, de, ge;
        logic [31:0] d0;
        int st, pl, pu, gl, prev, exp_idx;
        bit to;
        do_reset();
        for (int i = 0; i < N; i++) set_slot(i, 32'(100 + i), 32'd3);
        req = '1;
        prev = 0;
        exp_idx = N - 1;
        for (int k = 0; k < 5; k++) begin
            exp_idx = rr_pick(exp_idx, req);
            observe(g0, d0, st, pl, de, ge, pu, gl, to);
            checks++; if (to) begin errors++; $display("FAIL b2b_timeout: grant %0d", k); end
            checks++; if (g0 !== 4'(1 << exp_idx)) begin errors++; $display("FAIL b2b_order: grant %0d got %b expected %b", k, g0, 4'(1 << exp_idx)); end
            checks++; if (d0 !== 32'(100 + exp_idx)) begin errors++; $display("FAIL b2b_divisor: grant %0d got %0d expected %0d", k, d0, 100 + exp_idx); end
            checks++; if (pl !== 3) begin errors++; $display("FAIL b2b_play_len: grant %0d got %0d expected 3", k, pl); end
            checks++; if (de !== g0 || pu !== 1) begin errors++; $display("FAIL b2b_done: grant %0d got %b x%0d expected %b x1", k, de, pu, g0); end
            if (k > 0) begin
                checks++; if (st - prev !== 3 + GAP + 1) begin errors++; $display("FAIL b2b_spacing: grant %0d got %0d expected %0d", k, st - prev, 3 + GAP + 1); end
            end
            prev = st;
        end
        req = '0;
        step();
    endtask

    task automatic test_zero_duration();
        logic [N-1:0] g0, de, ge;
        logic [31:0] d0;
        int st, pl, pu, gl;
        bit to;
        set_slot(1, 32'd77, 32'd0);
        req = 4'b0010;
        observe(g0, d0, st, pl, de, ge, pu, gl, to);
        req = '0;
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: no completed grant"); end
        checks++; if (pl !== 1) begin errors++; $display("FAIL zero_play_len: got %0d expected 1", pl); end
        checks++; if (de !== 4'b0010) begin errors++; $display("FAIL zero_done: got %b expected 0010", de); end
    endtask

    task automatic test_abort();
        int budget, gl, pu;
        set_slot(0, 32'd1000, 32'd10);
        req = 4'b0001;
        budget = 0;
        do begin step(); budget++; end while (grant === '0 && budget < 100);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL abort_grant: got %b expected 0001", grant); end
        step();
        req = '0;
        step();
        checks++; if (grant !== '0) begin errors++; $display("FAIL abort_grant_clear: got %b expected 0000", grant); end
        checks++; if (done !== '0) begin errors++; $display("FAIL abort_no_done: got %b expected 0000", done); end
        checks++; if (tone_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_gap_entry: tone_en=%b busy=%b expected 0 1", tone_en, busy); end
        gl = 0; pu = 0; budget = 0;
        while (busy === 1'b1 && budget < 200) begin
            if (done !== '0) pu++;
            gl++;
            step();
            budget++;
        end
        checks++; if (gl !== GAP || pu !== 0) begin errors++; $display("FAIL abort_gap: got %0d cycles %0d pulses expected %0d cycles 0 pulses", gl, pu, GAP); end
    endtask

    task automatic test_divisor_hold();
        int budget, bad;
        set_slot(0, 32'd1000, 32'd8);
        req = 4'b0001;
        budget = 0;
        do begin step(); budget++; end while (grant === '0 && budget < 100);
        req_divisor[0 +: DW] = 32'd50;
        bad = 0; budget = 0;
        while (busy === 1'b1 && budget < 200) begin
            if (divisor !== 32'd1000) bad++;
            step();
            budget++;
        end
        checks++; if (bad !== 0 || busy !== 1'b0) begin errors++; $display("FAIL divhold_held: %0d cycles differed from 1000, busy=%b expected 0 and 0", bad, busy); end
        step();
        checks++; if (grant !== 4'b0001 || divisor !== 32'd50) begin errors++; $display("FAIL divhold_next: grant=%b divisor=%0d expected 0001 50", grant, divisor); end
        req = '0;
        budget = 0;
        while (busy === 1'b1 && budget < 200) begin step(); budget++; end
    endtask

    task automatic test_reset_mid_play();
        int budget;
        set_slot(0, 32'd1000, 32'd10);
        set_slot(3, 32'd333, 32'd4);
        req = 4'b0001;
        budget = 0;
        do begin step(); budget++; end while (grant === '0 && budget < 100);
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({grant, done, tone_en, busy} !== '0 || divisor !== '0) begin
            errors++; $display("FAIL midreset_outputs: grant=%b done=%b tone_en=%b busy=%b divisor=%0d expected all 0", grant, done, tone_en, busy, divisor);
        end
        req = 4'b1001;
        step();
        reset = 1'b1;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midreset_pointer_1001: got %b expected 0001", grant); end
        req = '0;
        do_reset();
        req = 4'b1000;
        step();
        checks++; if (grant !== 4'b1000 || divisor !== 32'd333) begin errors++; $display("FAIL midreset_req3: grant=%b divisor=%0d expected 1000 333", grant, divisor); end
        req = '0;
        budget = 0;
        while (busy === 1'b1 && budget < 200) begin step(); budget++; end
    endtask

    task automatic test_random();
        logic [N-1:0] g0, de, ge, mask;
        logic [31:0] d0, exp_len;
        int st, pl, pu, gl, last_m, w;
        bit to;
        do_reset();
        last_m = N - 1;
        for (int it = 0; it < 12; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) set_slot(i, $urandom, 32'($urandom_range(0, 6)));
            req = mask;
            w = rr_pick(last_m, mask);
            exp_len = (dur_m[w] == 0) ? 32'd1 : dur_m[w];
            observe(g0, d0, st, pl, de, ge, pu, gl, to);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout: iter %0d", it); end
            checks++; if (g0 !== 4'(1 << w)) begin errors++; $display("FAIL rand_grant: iter %0d mask %b got %b expected %b", it, mask, g0, 4'(1 << w)); end
            checks++; if (d0 !== div_m[w]) begin errors++; $display("FAIL rand_divisor: iter %0d got %0h expected %0h", it, d0, div_m[w]); end
            checks++; if (pl !== int'(exp_len)) begin errors++; $display("FAIL rand_play_len: iter %0d got %0d expected %0d", it, pl, exp_len); end
            checks++; if (de !== 4'(1 << w) || pu !== 1) begin errors++; $display("FAIL rand_done: iter %0d got %b x%0d expected %b x1", it, de, pu, 4'(1 << w)); end
            checks++; if (gl !== GAP) begin errors++; $display("FAIL rand_gap: iter %0d got %0d expected %0d", it, gl, GAP); end
            last_m = w;
        end
        req = '0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_duration();
        test_abort();
        test_divisor_hold();
        test_reset_mid_play();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Time-shares a single frequency divider between several tone requesters. Each requester asks for a divisor and a play duration. The block grants requesters round-robin and drives the divider's `divisor` input for the requested number of clock cycles. It then inserts a fixed silent gap before the next grant. It sits between the note/tone sources and the frequency divider feeding the audio output.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `DIV_W`, 32: divisor width, matches the divider's divisor input
- `DUR_W`, 32: duration counter width
- `GAP_CYCLES`, 16: silent cycles between consecutive grants; 0 means no gap
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low
- `req` in NUM_REQ: level request per requester; held until `done` or withdrawn
- `req_divisor` in NUM_REQ*DIV_W: packed; slice i belongs to requester i
- `req_duration` in NUM_REQ*DUR_W: packed; slice i = play length in clk cycles
- `grant` out NUM_REQ: one-hot owner, registered
- `done` out NUM_REQ: one-cycle pulse to the owner on normal completion
- `divisor` out DIV_W: to the frequency divider
- `tone_en` out 1: high while the divider output is to be heard
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, PLAY, GAP.
- IDLE, no `req`: stay in IDLE.
- IDLE, any `req`:
  - Pick the winner by round-robin; search starts at `last+1` modulo NUM_REQ.
  - Capture that requester's divisor and duration into registers.
  - Set the matching `grant` bit, go to PLAY.
  - Set `last` to the winner.
- PLAY:
  - `tone_en`=1; duration counter counts up from 1.
  - When the count reaches the captured duration, pulse `done[owner]`, clear `grant`, go to GAP.
  - Captured duration 0 is treated as 1.
- Abort: owner drops `req` during PLAY → next edge clears `grant`, goes to GAP, and no `done` pulse.
- GAP:
  - `tone_en`=0; `divisor` holds its last value.
  - Count GAP_CYCLES, then go to IDLE.
  - If GAP_CYCLES=0, PLAY exits directly to IDLE.
- Input changes to `req_divisor`/`req_duration` after capture are ignored.
- `divisor` = 0 is passed through unmodified; the divider toggles every cycle.
- Counters are DUR_W bits wide and never wrap. The comparison is equality against the captured value, which is at most 2^DUR_W−1.

## Timing
- Reset (asynchronous assert) outputs:
  - `grant`=0, `done`=0, `divisor`=0, `tone_en`=0, `busy`=0.
  - State IDLE; `last`=NUM_REQ−1, so requester 0 has first priority.
- Reset mid-PLAY: outputs drop immediately, with no `done` pulse.
- Latency, `req` to play: `req` sampled high at edge N in IDLE → `grant`, `divisor`, `tone_en`, `busy` valid after edge N.
- PLAY length: `tone_en` is high for exactly max(duration,1) cycles.
- Completion edge: `done` pulse, `grant` clear and `tone_en` low all change on the same edge.
- Gap: lasts GAP_CYCLES cycles, then IDLE for one cycle before the next grant.
  - Back-to-back grant spacing = duration + GAP_CYCLES + 1 cycles.
- Simultaneous requests in IDLE: exactly one grant, by round-robin order.
- A requester re-asserting `req` during its own GAP is served only after the others waiting, per the round-robin order.

## Structure
- Package `tone_sched_pkg`:
  - State enum `tone_state_t` {IDLE, PLAY, GAP}.
  - Default constant `DIV_W_DEFAULT`=32.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: `req`, `last`.
  - Outputs: one-hot `pick` and its index, plus `any`.
- The top holds the FSM, capture registers and the duration/gap counter.

## Test plan
- Reset, then `req`=0001, divisor=1000, duration=5:
  - `grant`=0001 and `divisor`=1000 one edge later.
  - `tone_en` high for 5 cycles, `done[0]` pulse.
  - 16 cycles with `tone_en`=0, then `busy`=0.
- All four `req` held continuously with duration=3: grant order 0,1,2,3,0.
  - Grants are spaced 3+16+1=20 cycles apart.
  - Each completed grant gives exactly one `done` pulse to its owner.
- Duration=0: `tone_en` is high for exactly 1 cycle, then `done`.
- Owner drops `req` on PLAY cycle 2 of 10: `grant` clears next edge, no `done`, enters GAP.
- Change `req_divisor[0]` from 1000 to 50 during PLAY: `divisor` stays 1000 until the next grant.
- Assert `reset` low mid-PLAY: all outputs 0 immediately. After release with `req`=1000, requester 3 is granted first (priority pointer reset).
